// File: rtl/bram_flag_fifo_pkg.sv
// Shared FIFO constants: depth/count-width derivation and flag-level checks.
// Imported by the flag FIFO control and its storage.
package bram_flag_fifo_pkg;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_RW   = 2'b11
    } fifo_op_e;

    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

    function automatic int count_width(input int aw);
        return aw + 1;
    endfunction

    // Both thresholds must sit inside the occupancy range, AE strictly below AF.
    function automatic bit levels_ok(input int aw, input int af, input int ae);
        return (ae >= 0) && (ae < af) && (af <= fifo_depth(aw));
    endfunction

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port.
// Storage array is never reset; only the read register is.
module bram_sdp
    import bram_flag_fifo_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = fifo_depth(AW);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/bram_flag_fifo.sv
// Synchronous FIFO over a dual-port RAM with level flags and sticky errors.
// Flags decode the registered count only; reads land on dest_data next cycle.
module bram_flag_fifo
    import bram_flag_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 2**ADDR_WIDTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] src_data,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dest_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int CW    = count_width(ADDR_WIDTH);

    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

    generate
        if (!levels_ok(ADDR_WIDTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
            $error("bram_flag_fifo: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
        end
    endgenerate

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_ok;
    logic                  rd_ok;
    fifo_op_e              op;

    assign full         = (count == FULL_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // A read at full still proceeds; the write is refused that cycle.
    assign wr_ok = wr_en && !full && !rst;
    assign rd_ok = rd_en && !empty && !rst;
    assign op    = fifo_op_e'({wr_ok, rd_ok});

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case (op)
                OP_WR:   count <= count + 1'b1;
                OP_RD:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    bram_sdp #(
        .DW (DATA_WIDTH),
        .AW (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (src_data),
        .re    (rd_ok),
        .raddr (rd_ptr),
        .rdata (dest_data)
    );

endmodule

// File: tb/tb_bram_flag_fifo.sv
// Directed bench for bram_flag_fifo with a queue-based occupancy model.
// Every falling edge compares the DUT against the model; literals pin the model.
module tb_bram_flag_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] src_data;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] dest_data;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    int n_checks = 0;
    int n_errors = 0;

    bram_flag_fifo #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (3),
        .AF_LEVEL   (7),
        .AE_LEVEL   (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .src_data     (src_data),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .dest_data    (dest_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain queue of stored words plus sticky bits.
    logic [7:0] q [$];
    logic [7:0] m_dout;
    bit         m_ovf;
    bit         m_unf;
    bit         m_valid = 1'b0;

    always @(posedge clk) begin
        bit was_full;
        bit was_empty;
        was_full  = (q.size() == 8);
        was_empty = (q.size() == 0);
        if (rst) begin
            q.delete();
            m_dout  = 8'h00;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_valid = 1'b1;
        end else begin
            if (rd_en && !was_empty) m_dout = q.pop_front();
            if (wr_en && !was_full) q.push_back(src_data);
            if (wr_en && was_full) m_ovf = 1'b1;
            if (rd_en && was_empty) m_unf = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_count", 32'(count), 32'(q.size()));
            chk("m_full", 32'(full), 32'(q.size() == 8));
            chk("m_empty", 32'(empty), 32'(q.size() == 0));
            chk("m_afull", 32'(almost_full), 32'(q.size() >= 7));
            chk("m_aempty", 32'(almost_empty), 32'(q.size() <= 1));
            chk("m_dout", 32'(dest_data), 32'(m_dout));
            chk("m_ovf", 32'(overflow), 32'(m_ovf));
            chk("m_unf", 32'(underflow), 32'(m_unf));
        end
    end

    task automatic step(input bit w, input logic [7:0] d, input bit r, input bit rs);
        wr_en    = w;
        src_data = d;
        rd_en    = r;
        rst      = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string tag, input int e_cnt, input bit e_full,
                             input bit e_af, input bit e_empty, input bit e_ae);
        chk({tag, "_count"}, 32'(count), 32'(e_cnt));
        chk({tag, "_full"}, 32'(full), 32'(e_full));
        chk({tag, "_afull"}, 32'(almost_full), 32'(e_af));
        chk({tag, "_empty"}, 32'(empty), 32'(e_empty));
        chk({tag, "_aempty"}, 32'(almost_empty), 32'(e_ae));
    endtask

    initial begin
        rst      = 1'b1;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        src_data = 8'h00;
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h55, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        chk_flags("reset", 0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("reset_dout", 32'(dest_data), 32'h00);
        chk("reset_ovf", 32'(overflow), 32'd0);
        chk("reset_unf", 32'(underflow), 32'd0);

        // Fill then drain
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        chk_flags("fill", 8, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_dout", 32'(dest_data), 32'(8'h10 + i));
        end
        chk_flags("drained", 0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Thresholds
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        chk_flags("thr6", 6, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h26, 1'b0, 1'b0);
        chk_flags("thr7", 7, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk_flags("thr2", 2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk_flags("thr1", 1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("thr1_dout", 32'(dest_data), 32'h25);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("thr_last", 32'(dest_data), 32'h26);

        // Underflow
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("unf_flag", 32'(underflow), 32'd1);
        chk("unf_dout", 32'(dest_data), 32'h26);
        chk("unf_count", 32'(count), 32'd0);
        chk("unf_noovf", 32'(overflow), 32'd0);

        // Overflow with a simultaneous read
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("rst_unf", 32'(underflow), 32'd0);
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd7);
        chk("ovf_dout", 32'(dest_data), 32'h30);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            chk("ovf_drain", 32'(dest_data), 32'(8'h31 + i));
        end
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("ovf_empty", 32'(empty), 32'd1);

        // Wrap with simultaneous traffic at count 3
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(8'h50 + i), 1'b1, 1'b0);
            chk("wrap_count", 32'(count), 32'd3);
            chk("wrap_dout", 32'(dest_data),
                (i < 3) ? 32'(8'h40 + i) : 32'(8'h50 + i - 3));
        end

        // Mid-operation reset
        step(1'b1, 8'h60, 1'b0, 1'b0);
        step(1'b1, 8'h61, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd5);
        step(1'b1, 8'h62, 1'b0, 1'b1);
        chk_flags("midrst", 0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        chk("midrst_unf", 32'(underflow), 32'd0);
        chk("midrst_dout", 32'(dest_data), 32'h00);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bram_flag_fifo.md
BRAM_FLAG_FIFO -- requirements
Module: bram_flag_fifo

Interface
REQ-001 Parameters SHALL be as follows; name, default, meaning, one per line:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 3, address width; DEPTH = 2**ADDR_WIDTH words.
- AF_LEVEL, 2**ADDR_WIDTH-1, almost_full threshold in words.
- AE_LEVEL, 1, almost_empty threshold in words.
REQ-002 Ports SHALL be as follows; name, direction, width, meaning, one per line:
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, synchronous active-high reset.
- src_data, in, DATA_WIDTH, write data.
- wr_en, in, 1, write request.
- rd_en, in, 1, read request.
- dest_data, out, DATA_WIDTH, registered read data.
- full, out, 1, count == DEPTH.
- empty, out, 1, count == 0.
- almost_full, out, 1, count >= AF_LEVEL.
- almost_empty, out, 1, count <= AE_LEVEL.
- count, out, ADDR_WIDTH+1, words stored.
- overflow, out, 1, sticky: write attempted while full.
- underflow, out, 1, sticky: read attempted while empty.
REQ-003 The block SHALL have one clock, clk; reset rst is synchronous and active-high.

Function
REQ-004 Write acceptance SHALL be wr_en && !full && !rst; read acceptance SHALL be rd_en && !empty && !rst.
REQ-005 An accepted write SHALL store src_data at the write pointer and increment it modulo DEPTH.
REQ-006 An accepted read SHALL register the head word onto dest_data at the same edge (valid the following cycle) and increment the read pointer modulo DEPTH.
REQ-007 dest_data SHALL hold its last value when no read is accepted.
REQ-008 count SHALL change as follows: +1 on write only, -1 on read only, unchanged on simultaneous accepted read and write.
REQ-009 Flags SHALL be decoded from the registered count only, with no combinational path from wr_en or rd_en.
REQ-010 Simultaneous accepted read and write at count 0 SHALL NOT occur; read is rejected at count 0.
REQ-011 When full, a write SHALL be rejected even if a read is accepted in the same cycle; the read proceeds and overflow sets.
REQ-012 overflow SHALL set at the edge where wr_en && full && !rst and stay set until rst.
REQ-013 underflow SHALL set at the edge where rd_en && empty && !rst and stay set until rst.
REQ-014 Rejected operations SHALL change neither the pointers, count nor memory.
REQ-015 Reads SHALL return words in write order across pointer wrap-around for any DEPTH.
REQ-016 Parameters SHALL satisfy 0 <= AE_LEVEL < AF_LEVEL <= DEPTH; violation SHALL stop elaboration.

Reset
REQ-017 Reset SHALL set the following: pointers 0, count 0, dest_data 0, overflow 0, underflow 0.
REQ-018 The cycle after reset, outputs SHALL be: empty=1, almost_empty=1, full=0, almost_full=0.
REQ-019 rst SHALL override wr_en and rd_en in the same cycle, including mid-fill and mid-drain.
REQ-020 Memory contents SHALL NOT be reset.

Structure
REQ-021 Flag-threshold range checks and the DEPTH/count-width derivation SHALL live in the shared fifo constants package.
REQ-022 Storage SHALL be one sub-module, bram_sdp: simple dual-port, one write port, one registered read port, same clk.
REQ-023 Control (pointers, count, flags, sticky errors) SHALL reside in bram_flag_fifo.

Verification
REQ-024 The bench SHALL cover these scenarios with DATA_WIDTH=8, ADDR_WIDTH=3, AF_LEVEL=7, AE_LEVEL=1:
- Fill then drain: write 0x10..0x17 -> full=1, count=8; read 8 times -> dest_data 0x10..0x17 in order, empty=1.
- Thresholds: write 7 words -> almost_full=1, full=0; read 6 -> almost_empty=1 at count=1.
- Overflow: at full, write 0xAA with rd_en=1 -> read proceeds, count=7, overflow=1, 0xAA never read out.
- Underflow: at empty, rd_en=1 -> underflow=1, dest_data unchanged, count=0.
- Wrap: 20 cycles of simultaneous write/read at count=3 -> count stays 3, data order preserved across pointer wrap.
- Mid-operation reset: rst at count=5 with wr_en=1 -> next cycle count=0, empty=1, overflow=0, underflow=0.
REQ-025 A formal harness SHALL prove the following against a shift-register reference model with unconstrained wr_en and rd_en:
- data order;
- count == reference occupancy;
- count <= DEPTH.
